// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-outstanding arbiter sharing one memory port between IFU and LSU.
// MEM_ARB_RR_EN selects round-robin arbitration; otherwise LSU has fixed priority.
module mem_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wmask_q, wmask_d;
   logic                grant_lsu;
`ifdef MEM_ARB_RR_EN
   logic                last_q, last_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
`ifdef MEM_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      addr_d        = addr_q;
      wen_d         = wen_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      grant_lsu     = 1'b0;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d        = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (ifu_req_valid || lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
               // last_q = 1 means LSU was granted last, so IFU wins a tie
               grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_q);
               last_d    = grant_lsu;
`else
               grant_lsu = lsu_req_valid;
`endif
               owner_d = grant_lsu;
               state_d = REQ;
               if (grant_lsu) begin
                  lsu_req_ready = 1'b1;
                  addr_d        = lsu_addr;
                  wen_d         = lsu_wen;
                  wdata_d       = lsu_wdata;
                  wmask_d       = lsu_wmask;
               end else begin
                  ifu_req_ready = 1'b1;
                  addr_d        = ifu_addr;
                  wen_d         = 1'b0;
                  wdata_d       = '0;
                  wmask_d       = '0;
               end
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = RSP;
         end
         RSP: begin
            if (mem_rsp_valid) begin
               ifu_rsp_valid = !owner_q;
               lsu_rsp_valid = owner_q;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr     = addr_q;
   assign mem_wen      = wen_q;
   assign mem_wdata    = wdata_q;
   assign mem_wmask    = wmask_q;
   assign ifu_rsp_data = mem_rsp_data;
   assign lsu_rsp_data = mem_rsp_data;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb (default or MEM_ARB_RR_EN build).
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_addr, ifu_rsp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
   logic [3:0]  mem_wmask;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mreq_t;
   typedef struct {
      logic        lsu;
      logic [31:0] data;
   } rsp_t;

   mreq_t mreq_q[$];
   rsp_t  rsp_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: memory handshakes and routed responses
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req_valid && mem_req_ready) begin
            if (mreq_q.size() == 0) chk("mem_req_unexpected", 1, 0);
            else begin
               mreq_t e;
               e = mreq_q.pop_front();
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_wen", mem_wen, e.wen);
               chk("mem_wmask", mem_wmask, e.wmask);
               if (e.wen) chk("mem_wdata", mem_wdata, e.wdata);
            end
         end
         if (ifu_rsp_valid || lsu_rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("rsp_route", {ifu_rsp_valid, lsu_rsp_valid}, r.lsu ? 2'b01 : 2'b10);
               chk("rsp_data", r.lsu ? lsu_rsp_data : ifu_rsp_data, r.data);
            end
         end
      end
   end

   // Caller raises the requester valid(s) at posedge+1 while the DUT is IDLE
   task automatic do_grant(input logic exp_lsu, input logic [31:0] rdata);
      mreq_t m;
      rsp_t  r;
      @(negedge clk);
      chk("lsu_req_ready", lsu_req_ready, exp_lsu);
      chk("ifu_req_ready", ifu_req_ready, !exp_lsu);
      if (exp_lsu) begin
         m.addr = lsu_addr; m.wen = lsu_wen; m.wdata = lsu_wdata; m.wmask = lsu_wmask;
      end else begin
         m.addr = ifu_addr; m.wen = 1'b0; m.wdata = '0; m.wmask = 4'h0;
      end
      mreq_q.push_back(m);
      r.lsu = exp_lsu; r.data = rdata;
      rsp_q.push_back(r);
      tick();
      if (exp_lsu) lsu_req_valid = 1'b0;
      else ifu_req_valid = 1'b0;
   endtask

   task automatic serve(input int wait_n, input logic [31:0] exp_addr, input logic [31:0] rdata);
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         chk("hold_valid", mem_req_valid, 1);
         chk("hold_addr", mem_addr, exp_addr);
         chk("hold_busy", busy, 1);
         chk("hold_no_ready", {ifu_req_ready, lsu_req_ready}, 0);
         tick();
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_addr, exp_addr);
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rdata;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
   endtask

   initial begin
      rst_n = 1'b1;
      {ifu_req_valid, lsu_req_valid, lsu_wen, mem_req_ready, mem_rsp_valid} = '0;
      ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_rsp_data = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, 0);
      chk("rst_fields", {mem_addr, mem_wen, mem_wmask}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // IFU-only fetch, minimum latency
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      do_grant(1'b0, 32'h0010_0073);
      serve(0, 32'h8000_0000, 32'h0010_0073);

      // Both valid: LSU store wins first, then IFU alone
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
      lsu_wdata = 32'h0000_1234; lsu_wmask = 4'hF;
      do_grant(1'b1, 32'h0);
      serve(0, 32'h8000_1000, 32'h0);
      do_grant(1'b0, 32'h1111_2222);
      serve(0, 32'h8000_0004, 32'h1111_2222);
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1008;
      do_grant(1'b1, 32'h3333_4444);
      serve(0, 32'h8000_1008, 32'h3333_4444);
      // Both valid after an LSU grant: the one tie where the two builds differ
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
`ifdef MEM_ARB_RR_EN
      do_grant(1'b0, 32'h5555_6666);
      serve(0, 32'h8000_0008, 32'h5555_6666);
`else
      do_grant(1'b1, 32'h5555_6666);
      serve(0, 32'h8000_1008, 32'h5555_6666);
`endif
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

      // Load stalled 5 cycles; LSU inputs change after handshake
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wmask = 4'h3;
      do_grant(1'b1, 32'hCAFE_F00D);
      lsu_addr = 32'h1234_5678; lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
      serve(5, 32'h8000_2000, 32'hCAFE_F00D);
      lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;

      // Spurious responses in IDLE and REQ
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0001;
      @(negedge clk);
      chk("spur_idle_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      chk("spur_idle_busy", busy, 0);
      tick();
      mem_rsp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
      do_grant(1'b0, 32'h7777_8888);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0002;
      @(negedge clk);
      chk("spur_req_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      tick();
      mem_rsp_valid = 1'b0;
      serve(1, 32'h8000_0010, 32'h7777_8888);

      // Reset while waiting in RSP
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
      @(negedge clk);
      chk("rr_ifu_ready", ifu_req_ready, 1);
      mreq_q.push_back('{addr: 32'h8000_0100, wen: 1'b0, wdata: 32'h0, wmask: 4'h0});
      tick();
      ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("in_rsp_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valids", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, 0);
      chk("arst_fields", {mem_addr, mem_wen, mem_wmask}, 0);
      tick();
      rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0003;
      @(negedge clk);
      chk("late_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      tick();
      mem_rsp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
      do_grant(1'b0, 32'h9999_AAAA);
      serve(1, 32'h8000_0200, 32'h9999_AAAA);

      repeat (3) tick();
      chk("sb_mreq_empty", mreq_q.size(), 0);
      chk("sb_rsp_empty", rsp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
